program_counter: RTL and testbench



---
 rtl/program_counter_pkg.sv | 16 +
 rtl/program_counter_pc_reg.sv | 24 ++
 rtl/program_counter.sv | 36 +++
 tb/tb_program_counter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/program_counter_pkg.sv
// Shared CPU address constants. The PC, instruction memory and next-PC
// logic all import these so that width and reset vector agree everywhere.
package program_counter_pkg;

  // Instruction address width in bits.
  localparam int ADDR_WIDTH = 16;

  // Address fetched first after reset.
  localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'h0000;

  // Current PC register contents, grouped so a checker can bind to one signal.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
  } pc_state_t;

endpackage

// File: rtl/program_counter_pc_reg.sv
// Generic WIDTH-bit register with synchronous active-low reset to a
// parameterised value and a load enable. Reset wins over enable; with
// enable low the stored value holds, so an undriven d cannot leak in.
module pc_reg #(
  parameter int                 WIDTH       = 16,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage element: reset first, then enabled load, otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/program_counter.sv
// Program counter: holds the current instruction address and presents it
// straight from a register to the instruction-fetch port. The next address
// is computed outside (branch/jump/increment mux); this block only stores
// it, so there is no arithmetic and wrap-around is the caller's concern.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int                WIDTH      = ADDR_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_ADDR = RESET_VECTOR
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Enable,
  input  logic [WIDTH-1:0] PCWriteAddr,
  output logic [WIDTH-1:0] PCReadAddr
);

  logic [WIDTH-1:0] pc_q;

  // The single PC register; one cycle load latency, no extra pipeline.
  pc_reg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_ADDR)
  ) u_pc_reg (
    .clk   (Clk),
    .rst_n (Rst),
    .en    (Enable),
    .d     (PCWriteAddr),
    .q     (pc_q)
  );

  // Register output drives the fetch port directly; no input reaches it
  // combinationally.
  assign PCReadAddr = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter. Each step drives inputs on the
// falling edge, pushes the value PCReadAddr must show after the next rising
// edge, then pops and compares 1 ns after that edge.
module tb_program_counter;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         enable;
  logic [W-1:0] write_addr;
  logic [W-1:0] read_addr;

  logic [W-1:0] exp_q[$];
  int           errors = 0;
  int           checks = 0;

  program_counter dut (
    .Clk         (clk),
    .Rst         (rst),
    .Enable      (enable),
    .PCWriteAddr (write_addr),
    .PCReadAddr  (read_addr)
  );

  // Clock and initial input levels.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expected value and compare it with the PC output now.
  task automatic check_out(input string tag);
    logic [W-1:0] exp_v;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed=%h expected=<empty queue>", tag, read_addr);
    end else begin
      exp_v = exp_q.pop_front();
      assert (read_addr === exp_v) else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, read_addr, exp_v);
      end
    end
  endtask

  // One full cycle: drive on the falling edge, check after the rising edge.
  task automatic step(input logic r, input logic en, input logic [W-1:0] addr,
                      input logic [W-1:0] exp_v, input string tag);
    @(negedge clk);
    rst        = r;
    enable     = en;
    write_addr = addr;
    exp_q.push_back(exp_v);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  initial begin
    rst        = 1'b0;
    enable     = 1'b0;
    write_addr = '0;

    // Reset with enable off, held for several edges.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0005, 16'h0000, "reset_en_off");

    // Reset beats enable.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'h1234, 16'h0000, "reset_priority");

    // Reset with garbage on the address bus must still give the reset vector.
    step(1'b0, 1'b1, 'x, 16'h0000, "reset_x_addr");

    // Release with enable high loads on the very first edge.
    step(1'b1, 1'b1, 16'h1234, 16'h1234, "release_load");

    // Tracking an incrementing next-PC one cycle behind.
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 16'h1235 + W'(i), 16'h1235 + W'(i), "track");
    end

    // Hold: enable low ignores a changed write address.
    step(1'b1, 1'b1, 16'h1240, 16'h1240, "load_1240");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'hBEEF, 16'h1240, "hold");
    step(1'b1, 1'b1, 16'hBEEF, 16'hBEEF, "hold_release");

    // Unknown address while disabled must not reach the register.
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 'x, 16'hBEEF, "hold_x_addr");

    // Boundary values are loaded verbatim, no wrap logic.
    step(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, "load_ffff");
    step(1'b1, 1'b1, 16'h0000, 16'h0000, "load_0000");

    // Random loads, each paired with a random hold cycle.
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] a;
      a = W'($urandom_range(0, 16'hFFFF));
      step(1'b1, 1'b1, a, a, "rand_load");
      step(1'b1, 1'b0, W'($urandom_range(0, 16'hFFFF)), a, "rand_hold");
    end

    // Mid-operation reset: stays at 0x0042 until the next rising edge.
    step(1'b1, 1'b1, 16'h0042, 16'h0042, "load_0042");
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b1;
    write_addr = 16'h5555;
    #1;
    exp_q.push_back(16'h0042);
    check_out("mid_reset_before_edge");
    exp_q.push_back(16'h0000);
    @(posedge clk);
    #1;
    check_out("mid_reset_after_edge");

    // Short reset pulse between edges is ignored.
    step(1'b1, 1'b1, 16'h0077, 16'h0077, "load_0077");
    @(negedge clk);
    enable = 1'b0;
    rst    = 1'b0;
    #2;
    rst    = 1'b1;
    exp_q.push_back(16'h0077);
    @(posedge clk);
    #1;
    check_out("short_reset_pulse");

    // Short enable pulse between edges is likewise ignored.
    @(negedge clk);
    write_addr = 16'hA5A5;
    enable     = 1'b1;
    #2;
    enable     = 1'b0;
    exp_q.push_back(16'h0077);
    @(posedge clk);
    #1;
    check_out("short_enable_pulse");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL leftover_queue: observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
